fifo_seq: RTL and testbench

Handshake sequencer for the `fifo` delay buffer, which has `DEPTH` stages, shifts on `en` and resets all stages to zero. It turns that free-running shift line into a valid/ready stream stage. It generates the buffer's shift enable and input data, and it mirrors stage occupancy with a valid-bit shadow register. It applies backpressure and can flush residual entries out with zero bubbles on command. It sits between a producer, such as an MMIO/DMA write path, and a consumer, such as a systolic-array row input. The buffer is instantiated externally with the same `DEPTH`, `BITS`, `clk` and `rst_n`.

---
 rtl/fifo_seq.sv | 178 +++++++++++++++++
 tb/tb_fifo_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_seq
//  Purpose  : Valid/ready handshake sequencer for an external DEPTH-stage
//             delay buffer (shift on en, all stages clear on reset). Drives
//             the buffer's shift enable and input data. A valid-bit shadow
//             register mirrors which stages hold live items. Applies
//             backpressure, and on a flush request pushes zeros in until
//             every live item has left the line.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH     stage count of the controlled delay buffer (>= 2)
//    BITS      data width
//  Ports
//    clk       clock, rising edge
//    rst_n     asynchronous active-low reset, shared with the buffer
//    in_valid  producer has data
//    in_data   producer data
//    in_ready  controller accepts in_data this cycle
//    flush     single-cycle request to drain all valid entries
//    fifo_en   shift enable to the buffer
//    fifo_d    data to the buffer input stage
//    fifo_q    buffer output (oldest stage)
//    out_valid oldest stage holds a valid item
//    out_ready consumer can take an item
//    out_data  item presented to the consumer (= fifo_q)
//    out_fire  item transferred to the consumer this cycle
//    count     number of valid items in the line
//    busy      controller is not idle
//    done      one-cycle pulse when a flush completes
// ============================================================================
module fifo_seq #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [BITS-1:0]              in_data,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         fifo_en,
    output logic [BITS-1:0]              fifo_d,
    input  logic [BITS-1:0]              fifo_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITS-1:0]              out_data,
    output logic                         out_fire,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         done
);

    localparam int c_CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    logic [DEPTH-1:0]     r_vld;     // bit i set: buffer stage i holds a live item
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_done;

    logic                 w_slot_free;
    logic                 w_in_fire;
    logic                 w_vld_in;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_cnt_zero;

    // ------------------------------------------------------------------
    // Handshake and shift control
    // ------------------------------------------------------------------
    // The oldest stage may only be overwritten by a shift when it is empty
    // or the consumer is taking it this cycle.
    assign out_valid   = r_vld[DEPTH-1];
    assign w_slot_free = !out_valid || out_ready;

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_RUN:   in_ready = w_slot_free;
            S_FLUSH: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_in_fire = in_valid && in_ready;

    // Outside FLUSH the line only moves when a new item enters, so the
    // oldest item waits at the output until the producer pushes again.
    // In FLUSH the line advances whenever the output slot allows it,
    // feeding zero-valued bubbles in behind the live items.
    assign fifo_en  = (r_state == S_FLUSH) ? w_slot_free : w_in_fire;

    // Gated so the buffer input is quiet (zero) whenever nothing is pushed;
    // this also gives fifo_d its zero reset value and zero fill during FLUSH.
    assign fifo_d   = w_in_fire ? in_data : '0;

    assign out_fire = fifo_en && out_valid;
    assign out_data = fifo_q;

    // in_fire is already 0 in FLUSH; the explicit state term documents that
    // flush fill never marks a stage valid.
    assign w_vld_in = w_in_fire && (r_state != S_FLUSH);

    // in_fire and out_fire can both be set only when the line moves, so the
    // count stays within [0, DEPTH] without saturation logic.
    always_comb begin
        w_cnt_next = r_count;
        if (w_in_fire && !out_fire) begin
            w_cnt_next = r_count + c_CNT_W'(1);
        end else if (out_fire && !w_in_fire) begin
            w_cnt_next = r_count - c_CNT_W'(1);
        end
    end

    assign w_cnt_zero = (w_cnt_next == '0);

    // ------------------------------------------------------------------
    // State, shadow register, count and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vld   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_count <= w_cnt_next;

            if (fifo_en) begin
                r_vld <= {r_vld[DEPTH-2:0], w_vld_in};
            end

            case (r_state)
                S_IDLE, S_RUN: begin
                    if (flush) begin
                        // An item accepted alongside the flush request is
                        // drained with the rest; nothing left means the
                        // flush is complete immediately.
                        if (w_cnt_zero) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end else if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    // Further flush requests are ignored here.
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_seq
//  Purpose  : Self-checking bench for fifo_seq with a behavioural model of
//             the external delay buffer. Accepted inputs are queued on the
//             scoreboard and popped against out_data on every out_fire.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_seq;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [BITS-1:0]   in_data;
    logic              in_ready;
    logic              flush;
    logic              fifo_en;
    logic [BITS-1:0]   fifo_d;
    logic [BITS-1:0]   fifo_q;
    logic              out_valid;
    logic              out_ready;
    logic [BITS-1:0]   out_data;
    logic              out_fire;
    logic [CW-1:0]     count;
    logic              busy;
    logic              done;

    int                n_vec;
    int                n_err;
    logic              mon_en;
    logic [BITS-1:0]   sb [$];
    logic [BITS-1:0]   r_exp;
    logic [BITS-1:0]   r_line [DEPTH];

    fifo_seq #(.DEPTH(DEPTH), .BITS(BITS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .fifo_en   (fifo_en),
        .fifo_d    (fifo_d),
        .fifo_q    (fifo_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_fire  (out_fire),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    // External delay buffer: shifts on en, clears every stage on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
        end else if (fifo_en) begin
            r_line[0] <= fifo_d;
            for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
        end
    end
    assign fifo_q = r_line[DEPTH-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change only just after a rising edge; checks happen on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_done(input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("count_vs_sb", 64'(count), 64'(sb.size()));
            if (out_fire) begin
                if (sb.size() == 0) begin
                    chk("fire_on_empty", 64'd1, 64'd0);
                end else begin
                    r_exp = sb.pop_front();
                    chk("out_data_fire", out_data, r_exp);
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_fifo_en"},   64'(fifo_en),   64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_fire"},  64'(out_fire),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_count"},     64'(count),     64'd0);
        chk({tag, "_fifo_d"},    fifo_d,         64'd0);
        chk({tag, "_out_data"},  out_data,       64'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'hDEAD;
        flush     = 1'b0;
        out_ready = 1'b0;

        #12;
        chk_reset_vals("rst");
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ---- Fill with consumer ready, push 1..8 ----
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            at_neg();
            chk("fill_in_ready", 64'(in_ready), 64'd1);
            chk("fill_out_valid_low", 64'(out_valid), 64'd0);
            tick();
        end
        // push 9: output appears and transfers on this shift
        in_data = 64'd9;
        at_neg();
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_out_data", out_data, 64'd1);
        chk("full_count", 64'(count), 64'd8);
        chk("push9_out_fire", 64'(out_fire), 64'd1);
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("push9_count", 64'(count), 64'd8);
        chk("hold_fifo_en", 64'(fifo_en), 64'd0);
        chk("hold_out_data", out_data, 64'd2);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        tick();

        // ---- Backpressure on a full line ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd10;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_fifo_en", 64'(fifo_en), 64'd0);
            chk("bp_count", 64'(count), 64'd8);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 64'(10 + k);
            at_neg();
            chk("bp_rel_fifo_en", 64'(fifo_en), 64'd1);
            chk("bp_rel_out_data", out_data, 64'(2 + k));
            tick();
        end
        in_valid = 1'b0;

        // drain by flush, stalling the first FLUSH cycle
        flush = 1'b1;
        at_neg();
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        at_neg();
        chk("stall_fifo_en", 64'(fifo_en), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        tick();
        at_neg();
        chk("stall_count", 64'(count), 64'd8);
        tick();
        out_ready = 1'b1;
        wait_done(20);
        chk("drain1_count", 64'(count), 64'd0);
        chk("drain1_busy", 64'(busy), 64'd0);
        chk("drain1_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // ---- Flush with 3 items 5,6,7 ----
        for (int i = 5; i <= 7; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        at_neg();
        chk("f3_busy_run", 64'(busy), 64'd1);
        tick();
        flush = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            at_neg();
            chk("f3_in_ready", 64'(in_ready), 64'd0);
            chk("f3_out_fire", 64'(out_fire), (c >= 6) ? 64'd1 : 64'd0);
            if (c >= 6) chk("f3_out_data", out_data, 64'(5 + c - 6));
            tick();
        end
        at_neg();
        chk("f3_done", 64'(done), 64'd1);
        chk("f3_busy", 64'(busy), 64'd0);
        chk("f3_count", 64'(count), 64'd0);
        tick();
        at_neg();
        chk("f3_done_once", 64'(done), 64'd0);
        tick();

        // ---- Flush while idle ----
        flush = 1'b1;
        at_neg();
        chk("fidle_busy0", 64'(busy), 64'd0);
        tick();
        flush = 1'b0;
        at_neg();
        chk("fidle_done", 64'(done), 64'd1);
        chk("fidle_busy1", 64'(busy), 64'd0);
        tick();
        at_neg();
        chk("fidle_done_clr", 64'(done), 64'd0);
        tick();

        // ---- Flush together with an input, count=2 ----
        in_valid = 1'b1;
        in_data  = 64'h11;
        tick();
        in_data  = 64'h22;
        tick();
        in_data  = 64'hA5;
        flush    = 1'b1;
        at_neg();
        chk("sim_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        at_neg();
        chk("sim_count_peak", 64'(count), 64'd3);
        chk("sim_busy", 64'(busy), 64'd1);
        chk("sim_in_ready_fl", 64'(in_ready), 64'd0);
        wait_done(20);
        chk("sim_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // ---- Reset in the middle of a flush ----
        in_valid = 1'b1;
        in_data  = 64'h33;
        tick();
        in_data  = 64'h44;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        tick();
        tick();
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk_reset_vals("midrst");
        sb.delete();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // refill: first item appears after DEPTH accepts
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 64'h1 : 64'(256 + i);
            at_neg();
            chk("refill_out_valid_low", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        at_neg();
        chk("refill_out_valid", 64'(out_valid), 64'd1);
        chk("refill_out_data", out_data, 64'h1);
        chk("refill_count", 64'(count), 64'd8);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done(20);
        chk("refill_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
